// File: rtl/blackjack_game_ctrl.sv
// Blackjack round sequencer: deals, runs player and dealer turns through a card
// request handshake, and settles the outcome from totals supplied by an external calculator.
module blackjack_game_ctrl #(
    parameter int DEALER_STAND = 17,
    parameter int MAX_CARDS    = 9
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic                       i_hit,
    input  logic                       i_stand,
    output logic                       o_card_req,
    input  logic                       i_card_valid,
    input  logic [3:0]                 i_card_value,
    input  logic [4:0]                 i_player_total,
    input  logic [4:0]                 i_dealer_total,
    output logic [MAX_CARDS-1:0][3:0]  o_player_cards,
    output logic [MAX_CARDS-1:0][3:0]  o_dealer_cards,
    output logic [3:0]                 o_player_count,
    output logic [3:0]                 o_dealer_count,
    output logic                       o_hole_hidden,
    output logic [1:0]                 o_result,
    output logic                       o_busy
);

    localparam logic [3:0] MAX_CNT   = 4'(MAX_CARDS);
    localparam logic [4:0] STAND_VAL = 5'(DEALER_STAND);

    typedef enum logic [3:0] {
        IDLE, DEAL, DEAL_WAIT, PLAYER_TURN, P_DRAW, P_WAIT,
        P_CHECK, DEALER_TURN, D_DRAW, D_WAIT, SETTLE, DONE
    } state_t;

    state_t r_state, w_nextState;

    logic [MAX_CARDS-1:0][3:0] r_playerCards, r_dealerCards;
    logic [3:0]                r_playerCount, r_dealerCount;
    logic [1:0]                r_dealIdx;
    logic                      r_holeHidden;
    logic [1:0]                r_result;

    logic       w_drawState, w_cardOk, w_capture, w_toPlayer, w_startRound;
    logic [1:0] w_settleResult;

    assign w_drawState  = (r_state == DEAL) || (r_state == P_DRAW) || (r_state == D_DRAW);
    assign w_cardOk     = (i_card_value >= 4'd1) && (i_card_value <= 4'd13);
    assign w_capture    = w_drawState && i_card_valid && w_cardOk;
    // Deal order alternates player, dealer, player, dealer on the low bit of the deal index.
    assign w_toPlayer   = (r_state == P_DRAW) || ((r_state == DEAL) && !r_dealIdx[0]);
    assign w_startRound = ((r_state == IDLE) || (r_state == DONE)) && i_start;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE, DONE:   if (i_start) w_nextState = DEAL;
            DEAL:         if (w_capture) w_nextState = DEAL_WAIT;
            // The deal index wraps to zero once the fourth card is in.
            DEAL_WAIT:    w_nextState = (r_dealIdx == 2'd0) ? PLAYER_TURN : DEAL;
            PLAYER_TURN: begin
                if (i_stand)    w_nextState = DEALER_TURN;
                else if (i_hit) w_nextState = P_DRAW;
            end
            P_DRAW:       if (w_capture) w_nextState = P_WAIT;
            P_WAIT:       w_nextState = P_CHECK;
            P_CHECK: begin
                if (i_player_total > 5'd21)
                    w_nextState = SETTLE;
                else if ((i_player_total == 5'd21) || (r_playerCount == MAX_CNT))
                    w_nextState = DEALER_TURN;
                else
                    w_nextState = PLAYER_TURN;
            end
            DEALER_TURN: begin
                if ((i_dealer_total < STAND_VAL) && (r_dealerCount < MAX_CNT))
                    w_nextState = D_DRAW;
                else
                    w_nextState = SETTLE;
            end
            D_DRAW:       if (w_capture) w_nextState = D_WAIT;
            D_WAIT:       w_nextState = DEALER_TURN;
            SETTLE:       w_nextState = DONE;
            default:      w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_settleResult = 2'b11;
        if (i_player_total > 5'd21)
            w_settleResult = 2'b10;
        else if (i_dealer_total > 5'd21)
            w_settleResult = 2'b01;
        else if (i_player_total > i_dealer_total)
            w_settleResult = 2'b01;
        else if (i_player_total < i_dealer_total)
            w_settleResult = 2'b10;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_playerCards <= '0;
            r_dealerCards <= '0;
            r_playerCount <= '0;
            r_dealerCount <= '0;
            r_dealIdx     <= '0;
            r_holeHidden  <= 1'b1;
            r_result      <= 2'b00;
        end else begin
            if (w_startRound) begin
                r_playerCards <= '0;
                r_dealerCards <= '0;
                r_playerCount <= '0;
                r_dealerCount <= '0;
                r_dealIdx     <= '0;
                r_holeHidden  <= 1'b1;
                r_result      <= 2'b00;
            end
            if (w_capture) begin
                if (w_toPlayer) begin
                    if (r_playerCount < MAX_CNT) begin
                        r_playerCards[r_playerCount] <= i_card_value;
                        r_playerCount                <= r_playerCount + 4'd1;
                    end
                end else begin
                    if (r_dealerCount < MAX_CNT) begin
                        r_dealerCards[r_dealerCount] <= i_card_value;
                        r_dealerCount                <= r_dealerCount + 4'd1;
                    end
                end
                if (r_state == DEAL) r_dealIdx <= r_dealIdx + 2'd1;
            end
            if (r_state == DEALER_TURN) r_holeHidden <= 1'b0;
            if (r_state == SETTLE)      r_result     <= w_settleResult;
        end
    end

    assign o_card_req     = w_drawState;
    assign o_busy         = (r_state != IDLE) && (r_state != DONE);
    assign o_player_cards = r_playerCards;
    assign o_dealer_cards = r_dealerCards;
    assign o_player_count = r_playerCount;
    assign o_dealer_count = r_dealerCount;
    assign o_hole_hidden  = r_holeHidden;
    assign o_result       = r_result;

endmodule

// File: tb/tb_blackjack_game_ctrl.sv
// Directed bench for blackjack_game_ctrl; emulates the card source and a one-stage
// registered hand-value calculator around the controller.
module tb_blackjack_game_ctrl;

    logic            clk = 1'b0;
    logic            rstN = 1'b0;
    logic            start = 1'b0, hit = 1'b0, stand = 1'b0;
    logic            cardReq;
    logic            cardValid = 1'b0;
    logic [3:0]      cardValue = 4'd0;
    logic [4:0]      playerTotal, dealerTotal;
    logic [8:0][3:0] playerCards, dealerCards;
    logic [3:0]      playerCount, dealerCount;
    logic            holeHidden;
    logic [1:0]      result;
    logic            busy;

    int checks = 0;
    int errors = 0;

    blackjack_game_ctrl dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_start        (start),
        .i_hit          (hit),
        .i_stand        (stand),
        .o_card_req     (cardReq),
        .i_card_valid   (cardValid),
        .i_card_value   (cardValue),
        .i_player_total (playerTotal),
        .i_dealer_total (dealerTotal),
        .o_player_cards (playerCards),
        .o_dealer_cards (dealerCards),
        .o_player_count (playerCount),
        .o_dealer_count (dealerCount),
        .o_hole_hidden  (holeHidden),
        .o_result       (result),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    // Soft-ace hand value, as the external calculator would produce it.
    function automatic logic [4:0] handValue(input logic [8:0][3:0] cards);
        int  sum = 0;
        bit  ace = 0;
        for (int i = 0; i < 9; i++) begin
            if (cards[i] == 4'd1) begin
                sum += 1;
                ace = 1;
            end else if (cards[i] >= 4'd10) sum += 10;
            else sum += int'(cards[i]);
        end
        if (ace && (sum + 10 <= 21)) sum += 10;
        if (sum > 31) sum = 31;
        return 5'(sum);
    endfunction

    always @(posedge clk) begin
        if (!rstN) begin
            playerTotal <= 5'd0;
            dealerTotal <= 5'd0;
        end else begin
            playerTotal <= handValue(playerCards);
            dealerTotal <= handValue(dealerCards);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dealCard(input logic [3:0] value);
        int waited = 0;
        while (!cardReq && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (!cardReq) begin
            errors++;
            $display("[TB] FAIL cardReqTimeout card=%0d actual req=%b required req=1", value, cardReq);
        end
        cardValid = 1'b1;
        cardValue = value;
        tick();
        cardValid = 1'b0;
        cardValue = 4'd0;
    endtask

    task automatic startRound(input logic [3:0] c0, c1, c2, c3);
        start = 1'b1;
        tick();
        start = 1'b0;
        dealCard(c0);
        dealCard(c1);
        dealCard(c2);
        dealCard(c3);
        tick();
    endtask

    task automatic pulseHit();
        hit = 1'b1;
        tick();
        hit = 1'b0;
    endtask

    task automatic pulseStand();
        stand = 1'b1;
        tick();
        stand = 1'b0;
    endtask

    task automatic waitDone();
        int waited = 0;
        while (busy && waited < 100) begin
            tick();
            waited++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("[TB] FAIL doneTimeout actual busy=%b required busy=0", busy);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        tick();
        tick();
        checks++;
        if ({cardReq, busy, holeHidden, result, playerCount, dealerCount} !== {1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL resetOutputs actual req=%b busy=%b hole=%b res=%b pc=%0d dc=%0d required 0 0 1 00 0 0",
                     cardReq, busy, holeHidden, result, playerCount, dealerCount);
        end
        checks++;
        if ({playerCards, dealerCards} !== '0) begin
            errors++;
            $display("[TB] FAIL resetSlots actual p=%h d=%h required all zero", playerCards, dealerCards);
        end
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_push();
        startRound(4'd10, 4'd5, 4'd7, 4'd9);
        checks++;
        if ({playerCards[0], playerCards[1], dealerCards[0], dealerCards[1]} !== {4'd10, 4'd7, 4'd5, 4'd9}) begin
            errors++;
            $display("[TB] FAIL dealOrder actual p0=%0d p1=%0d d0=%0d d1=%0d required 10 7 5 9",
                     playerCards[0], playerCards[1], dealerCards[0], dealerCards[1]);
        end
        checks++;
        if ({playerCount, dealerCount, holeHidden, busy, cardReq} !== {4'd2, 4'd2, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL dealState actual pc=%0d dc=%0d hole=%b busy=%b req=%b required 2 2 1 1 0",
                     playerCount, dealerCount, holeHidden, busy, cardReq);
        end
        pulseStand();
        dealCard(4'd3);
        waitDone();
        checks++;
        if ({result, dealerCount, dealerCards[2], holeHidden, playerCount} !== {2'b11, 4'd3, 4'd3, 1'b0, 4'd2}) begin
            errors++;
            $display("[TB] FAIL pushResult actual res=%b dc=%0d d2=%0d hole=%b pc=%0d required 11 3 3 0 2",
                     result, dealerCount, dealerCards[2], holeHidden, playerCount);
        end
        hit = 1'b1;
        stand = 1'b1;
        tick();
        hit = 1'b0;
        stand = 1'b0;
        tick();
        checks++;
        if ({busy, result, playerCount} !== {1'b0, 2'b11, 4'd2}) begin
            errors++;
            $display("[TB] FAIL doneHold actual busy=%b res=%b pc=%0d required 0 11 2", busy, result, playerCount);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, result, playerCount, dealerCount, holeHidden, cardReq} !== {1'b1, 2'b00, 4'd0, 4'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL restartClear actual busy=%b res=%b pc=%0d dc=%0d hole=%b req=%b required 1 00 0 0 1 1",
                     busy, result, playerCount, dealerCount, holeHidden, cardReq);
        end
        dealCard(4'd10);
        dealCard(4'd6);
        dealCard(4'd9);
        dealCard(4'd10);
        tick();
        pulseHit();
        dealCard(4'd5);
        waitDone();
        checks++;
        if ({result, playerCount, dealerCount, holeHidden} !== {2'b10, 4'd3, 4'd2, 1'b1}) begin
            errors++;
            $display("[TB] FAIL playerBust actual res=%b pc=%0d dc=%0d hole=%b required 10 3 2 1",
                     result, playerCount, dealerCount, holeHidden);
        end
    endtask

    task automatic test_twenty_one();
        startRound(4'd1, 4'd10, 4'd1, 4'd6);
        pulseHit();
        dealCard(4'd9);
        dealCard(4'd10);
        waitDone();
        checks++;
        if ({result, playerCount, dealerCount, dealerCards[2]} !== {2'b01, 4'd3, 4'd3, 4'd10}) begin
            errors++;
            $display("[TB] FAIL dealerBust actual res=%b pc=%0d dc=%0d d2=%0d required 01 3 3 10",
                     result, playerCount, dealerCount, dealerCards[2]);
        end
    endtask

    task automatic test_handshake();
        int reqLow = 0;
        startRound(4'd10, 4'd5, 4'd2, 4'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({playerCount, dealerCount, busy} !== {4'd2, 4'd2, 1'b1}) begin
            errors++;
            $display("[TB] FAIL startIgnored actual pc=%0d dc=%0d busy=%b required 2 2 1", playerCount, dealerCount, busy);
        end
        cardValid = 1'b1;
        cardValue = 4'd7;
        tick();
        cardValid = 1'b0;
        checks++;
        if ({playerCount, dealerCount} !== {4'd2, 4'd2}) begin
            errors++;
            $display("[TB] FAIL strayCard actual pc=%0d dc=%0d required 2 2", playerCount, dealerCount);
        end
        pulseHit();
        for (int i = 0; i < 5; i++) begin
            if (!cardReq) reqLow++;
            tick();
        end
        cardValid = 1'b1;
        cardValue = 4'd15;
        tick();
        checks++;
        if ({reqLow, cardReq, playerCount} !== {32'd0, 1'b1, 4'd2}) begin
            errors++;
            $display("[TB] FAIL reqHeld actual lowCycles=%0d req=%b pc=%0d required 0 1 2", reqLow, cardReq, playerCount);
        end
        cardValue = 4'd4;
        tick();
        cardValid = 1'b0;
        checks++;
        if ({playerCount, playerCards[2], cardReq} !== {4'd3, 4'd4, 1'b0}) begin
            errors++;
            $display("[TB] FAIL validCapture actual pc=%0d p2=%0d req=%b required 3 4 0", playerCount, playerCards[2], cardReq);
        end
        tick();
        tick();
        pulseStand();
        dealCard(4'd9);
        waitDone();
        checks++;
        if ({result, dealerCount} !== {2'b10, 4'd3}) begin
            errors++;
            $display("[TB] FAIL dealerWins actual res=%b dc=%0d required 10 3", result, dealerCount);
        end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        startRound(4'd10, 4'd5, 4'd2, 4'd3);
        pulseStand();
        while (!cardReq && waited < 10) begin
            tick();
            waited++;
        end
        checks++;
        if (cardReq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dealerReq actual req=%b required 1", cardReq);
        end
        rstN = 1'b0;
        cardValid = 1'b1;
        cardValue = 4'd5;
        tick();
        checks++;
        if ({cardReq, busy, holeHidden, result, playerCount, dealerCount, playerCards, dealerCards} !==
            {1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0, 36'd0, 36'd0}) begin
            errors++;
            $display("[TB] FAIL midReset actual req=%b busy=%b hole=%b res=%b pc=%0d dc=%0d d=%h required 0 0 1 00 0 0 0",
                     cardReq, busy, holeHidden, result, playerCount, dealerCount, dealerCards);
        end
        rstN = 1'b1;
        tick();
        cardValid = 1'b0;
        cardValue = 4'd0;
        tick();
        checks++;
        if ({busy, dealerCount, cardReq} !== {1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL postResetIdle actual busy=%b dc=%0d req=%b required 0 0 0", busy, dealerCount, cardReq);
        end
    endtask

    task automatic test_hit_stand();
        startRound(4'd10, 4'd5, 4'd2, 4'd3);
        hit = 1'b1;
        stand = 1'b1;
        tick();
        hit = 1'b0;
        stand = 1'b0;
        checks++;
        if ({playerCount, cardReq} !== {4'd2, 1'b0}) begin
            errors++;
            $display("[TB] FAIL hitStandTurn actual pc=%0d req=%b required 2 0", playerCount, cardReq);
        end
        tick();
        checks++;
        if ({cardReq, holeHidden} !== {1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL dealerDraws actual req=%b hole=%b required 1 0", cardReq, holeHidden);
        end
        dealCard(4'd9);
        waitDone();
        checks++;
        if ({result, playerCount, dealerCount} !== {2'b10, 4'd2, 4'd3}) begin
            errors++;
            $display("[TB] FAIL hitStandResult actual res=%b pc=%0d dc=%0d required 10 2 3", result, playerCount, dealerCount);
        end
    endtask

    initial begin
        test_reset();
        test_push();
        test_back_to_back();
        test_twenty_one();
        test_handshake();
        test_reset_mid();
        test_hit_stand();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
